shift_register_fifo_guarded: RTL and testbench

Parametrised shift-register FIFO: head entry always at stage 0, new data written at the tail. Successor to the basic shift-register FIFO, with four additions:
- Internal overflow/underflow guarding, so correctness no longer depends on environment constraints.
- Synchronous flush.
- Programmable almost-full/almost-empty thresholds.
- Occupancy output and sticky error flags.
Used as a small, low-latency buffer between datapath stages and as a formal-verification target.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_stage_ff.sv | 24 ++
 rtl/shift_register_fifo_guarded.sv | 110 +++++++++++
 tb/tb_shift_register_fifo_guarded.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: occupancy counter width and parameter legality checks.
package fifo_pkg;

  // Bits needed to hold an occupancy value from 0 to depth inclusive
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // True when the width, depth and threshold parameters describe a usable FIFO
  function automatic bit params_legal(input int width, input int depth,
                                      input int afull, input int aempty);
    return (width >= 1) && (depth >= 2) &&
           (afull >= 1) && (afull <= depth) &&
           (aempty >= 0) && (aempty <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_stage_ff.sv
// One FIFO storage stage: WIDTH-bit register with async reset, sync clear and enable.
module fifo_stage_ff #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Clear wins over a load so a flush always empties the stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/shift_register_fifo_guarded.sv
// Guarded shift-register FIFO: head lives in stage 0, writes land at the tail,
// with overflow/underflow protection, flush, thresholds and sticky error flags.
module shift_register_fifo_guarded
  import fifo_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 8,
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1,
  parameter int CNTWID        = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              pop,
  output logic [WIDTH-1:0]  data_out,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [CNTWID-1:0] count,
  output logic              push_ok,
  output logic              pop_ok,
  output logic              overflow,
  output logic              underflow
);

  if (!params_legal(WIDTH, DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_params
    $error("shift_register_fifo_guarded: illegal WIDTH/DEPTH/threshold parameters");
  end

  logic [WIDTH-1:0]  stage_q [DEPTH];
  logic [WIDTH-1:0]  stage_d [DEPTH];
  logic              stage_en;
  logic [CNTWID-1:0] count_next;
  logic [CNTWID-1:0] wr_idx;

  // Flags are pure decodes of the registered count, so they never glitch
  assign empty        = (count == '0);
  assign full         = (count == CNTWID'(DEPTH));
  assign almost_empty = (count <= CNTWID'(AEMPTY_THRESH));
  assign almost_full  = (count >= CNTWID'(AFULL_THRESH));
  assign data_out     = stage_q[0];

  // Acceptance: a pop frees a slot, so a full FIFO may still take a push alongside it
  assign pop_ok     = pop & ~empty & ~flush;
  assign push_ok    = push & (~full | pop_ok) & ~flush;
  assign count_next = count + CNTWID'(push_ok) - CNTWID'(pop_ok);
  assign wr_idx     = count - CNTWID'(pop_ok);
  assign stage_en   = push_ok | pop_ok;

  // Next value per stage: shift on pop, write at the tail on push, zero beyond the new count
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i];
      if (pop_ok) begin
        stage_d[i] = (i == DEPTH - 1) ? '0 : stage_q[(i + 1) % DEPTH];
      end
      if (push_ok && (wr_idx == CNTWID'(i))) begin
        stage_d[i] = data_in;
      end
      if (CNTWID'(i) >= count_next) begin
        stage_d[i] = '0;
      end
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    fifo_stage_ff #(.WIDTH(WIDTH)) u_stage (
      .clk (clk),
      .rst (rst),
      .clr (flush),
      .en  (stage_en),
      .d   (stage_d[gi]),
      .q   (stage_q[gi])
    );
  end

  // Occupancy counter; guarding above keeps it inside 0..DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  // Sticky error flags, cleared only by reset or flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && full && !pop_ok) begin
        overflow <= 1'b1;
      end
      if (pop && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shift_register_fifo_guarded.sv
// Directed bench: default-threshold FIFO plus a second instance with
// AFULL_THRESH=6 / AEMPTY_THRESH=2 driven by the same stimulus.
module tb_shift_register_fifo_guarded;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 8;
  localparam int CNTWID = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic [WIDTH-1:0] data_in = '0;

  logic [WIDTH-1:0]  data_out, t_data_out;
  logic              empty, full, almost_empty, almost_full;
  logic              t_empty, t_full, t_almost_empty, t_almost_full;
  logic [CNTWID-1:0] count, t_count;
  logic              push_ok, pop_ok, overflow, underflow;
  logic              t_push_ok, t_pop_ok, t_overflow, t_underflow;

  int checks = 0;
  int passes = 0;

  shift_register_fifo_guarded #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .data_in(data_in), .pop(pop),
    .data_out(data_out), .empty(empty), .full(full), .almost_empty(almost_empty),
    .almost_full(almost_full), .count(count), .push_ok(push_ok), .pop_ok(pop_ok),
    .overflow(overflow), .underflow(underflow)
  );

  shift_register_fifo_guarded #(.WIDTH(WIDTH), .DEPTH(DEPTH),
                                .AFULL_THRESH(6), .AEMPTY_THRESH(2)) dut_t (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .data_in(data_in), .pop(pop),
    .data_out(t_data_out), .empty(t_empty), .full(t_full), .almost_empty(t_almost_empty),
    .almost_full(t_almost_full), .count(t_count), .push_ok(t_push_ok), .pop_ok(t_pop_ok),
    .overflow(t_overflow), .underflow(t_underflow)
  );

  always #5 clk = ~clk;

  // Compare one observed value with its expected value and count the result
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drive one cycle's worth of inputs and let combinational outputs settle
  task automatic applyStimulus(input logic p, input logic [WIDTH-1:0] d, input logic q, input logic f);
    push    = p;
    data_in = d;
    pop     = q;
    flush   = f;
    #1;
  endtask

  // Take the clock edge, then return inputs to idle one step later
  task automatic stepClock();
    @(posedge clk);
    #1;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    data_in = '0;
  endtask

  // Flag checks on both instances against the count the bench expects
  task automatic checkFlags(input int n);
    checkOutput("count", 32'(count), 32'(n));
    checkOutput("t_count", 32'(t_count), 32'(n));
    checkOutput("empty", 32'(empty), 32'(n == 0));
    checkOutput("full", 32'(full), 32'(n == DEPTH));
    checkOutput("almost_full", 32'(almost_full), 32'(n >= 7));
    checkOutput("almost_empty", 32'(almost_empty), 32'(n <= 1));
    checkOutput("t_almost_full", 32'(t_almost_full), 32'(n >= 6));
    checkOutput("t_almost_empty", 32'(t_almost_empty), 32'(n <= 2));
  endtask

  logic [WIDTH-1:0] drain_exp [DEPTH];

  initial begin
    // Reset state while rst is held
    #3;
    checkFlags(0);
    checkOutput("rst_data_out", 32'(data_out), 32'h0);
    checkOutput("rst_overflow", 32'(overflow), 32'h0);
    checkOutput("rst_underflow", 32'(underflow), 32'h0);
    #5 rst = 1'b0;
    @(posedge clk); #1;

    // Reset mid-stream clears everything before the next edge
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0); stepClock();
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0); stepClock();
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0); stepClock();
    checkOutput("pre_rst_count", 32'(count), 32'd3);
    checkOutput("pre_rst_head", 32'(data_out), 32'h11);
    #1 rst = 1'b1;
    #1;
    checkOutput("async_rst_count", 32'(count), 32'd0);
    checkOutput("async_rst_data_out", 32'(data_out), 32'h0);
    checkOutput("async_rst_empty", 32'(empty), 32'd1);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(1'b1, 8'h44, 1'b0, 1'b0); stepClock();
    checkOutput("post_rst_head", 32'(data_out), 32'h44);
    checkOutput("post_rst_count", 32'(count), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0); stepClock();
    checkOutput("post_rst_drain_empty", 32'(empty), 32'd1);

    // Fill 0x01..0x08, watching flags and thresholds on every step
    for (int i = 1; i <= DEPTH; i++) begin
      applyStimulus(1'b1, WIDTH'(i), 1'b0, 1'b0);
      checkOutput("fill_push_ok", 32'(push_ok), 32'd1);
      stepClock();
      checkFlags(i);
      checkOutput("fill_head", 32'(data_out), 32'h01);
    end

    // Full with simultaneous push and pop: both accepted, count holds
    applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0);
    checkOutput("full_pp_push_ok", 32'(push_ok), 32'd1);
    checkOutput("full_pp_pop_ok", 32'(pop_ok), 32'd1);
    stepClock();
    checkOutput("full_pp_count", 32'(count), 32'd8);
    checkOutput("full_pp_head", 32'(data_out), 32'h02);
    checkOutput("full_pp_overflow", 32'(overflow), 32'd0);

    // Push into a full FIFO without pop is rejected and flagged
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
    checkOutput("ovf_push_ok", 32'(push_ok), 32'd0);
    stepClock();
    checkOutput("ovf_count", 32'(count), 32'd8);
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0); stepClock();
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);

    // Drain: 0x02..0x08 then 0xAA written at the tail
    for (int i = 0; i < DEPTH - 1; i++) drain_exp[i] = WIDTH'(i + 2);
    drain_exp[DEPTH-1] = 8'hAA;
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput("drain_head", 32'(data_out), 32'(drain_exp[i]));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("drain_pop_ok", 32'(pop_ok), 32'd1);
      stepClock();
      checkFlags(DEPTH - 1 - i);
    end
    checkOutput("drained_data_out", 32'(data_out), 32'h0);

    // Pop from empty is rejected and flagged
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("udf_pop_ok", 32'(pop_ok), 32'd0);
    stepClock();
    checkOutput("udf_flag", 32'(underflow), 32'd1);
    checkOutput("udf_count", 32'(count), 32'd0);

    // Empty with push and pop: push wins, pop rejected
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
    checkOutput("empty_pp_push_ok", 32'(push_ok), 32'd1);
    checkOutput("empty_pp_pop_ok", 32'(pop_ok), 32'd0);
    stepClock();
    checkOutput("empty_pp_count", 32'(count), 32'd1);
    checkOutput("empty_pp_head", 32'(data_out), 32'h77);

    // One entry, push and pop together: new data replaces the head
    applyStimulus(1'b1, 8'h66, 1'b1, 1'b0); stepClock();
    checkOutput("one_pp_count", 32'(count), 32'd1);
    checkOutput("one_pp_head", 32'(data_out), 32'h66);

    // Bring count to 5, then flush with push and pop asserted
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, WIDTH'(8'h81 + i), 1'b0, 1'b0); stepClock();
    end
    checkOutput("pre_flush_count", 32'(count), 32'd5);
    applyStimulus(1'b1, 8'h99, 1'b1, 1'b1);
    checkOutput("flush_push_ok", 32'(push_ok), 32'd0);
    checkOutput("flush_pop_ok", 32'(pop_ok), 32'd0);
    stepClock();
    checkFlags(0);
    checkOutput("flush_data_out", 32'(data_out), 32'h0);
    checkOutput("flush_overflow", 32'(overflow), 32'd0);
    checkOutput("flush_underflow", 32'(underflow), 32'd0);

    // After flush the next push lands at the head
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0); stepClock();
    checkOutput("post_flush_head", 32'(data_out), 32'h5A);
    checkOutput("post_flush_count", 32'(count), 32'd1);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
